// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg: screen geometry, pixel format, FSM encoding and row-base helper
package rect_fill_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int AW = 19;
  localparam int XW = 10;
  localparam int YW = 9;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
  function automatic logic [AW-1:0] row_base(input logic [YW-1:0] y);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < XW; i++) if (H_RES[i]) r = r + (AW'(y) << i);
    return r;
  endfunction
endpackage

// File: rtl/rect_clip.sv
// rect_clip: clamps the far corner to the screen and flags rectangles with nothing to draw
module rect_clip import rect_fill_pkg::*; (
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] cx1,
  output logic [YW-1:0] cy1,
  output logic          valid
);
  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_RES - 1);
  always_comb begin
    cx1 = x1 > XMAX ? XMAX : x1;
    cy1 = y1 > YMAX ? YMAX : y1;
    valid = x0 <= XMAX && y0 <= YMAX && x0 <= cx1 && y0 <= cy1;
  end
endmodule

// File: rtl/rect_fill.sv
// rect_fill: fills a clipped rectangle into VRAM in raster order, one pixel per ready cycle
module rect_fill import rect_fill_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y0,
  input  logic [YW-1:0] cmd_y1,
  input  logic [7:0]    cmd_color,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t state, state_n;
  logic [XW-1:0] x0, x1, x, cx1;
  logic [YW-1:0] y0, y1, y, cy1;
  logic [AW-1:0] base, addr;
  rgb332_t color;
  logic valid, bad, fire, row_end, last;
  rect_clip u_clip (.x0(x0), .x1(x1), .y0(y0), .y1(y1), .cx1(cx1), .cy1(cy1), .valid(valid));
  always_comb begin
    fire = state == FILL && wr_ready;
    row_end = x == x1;
    last = row_end && y == y1;
    state_n = state == IDLE  ? (cmd_valid ? SETUP : IDLE) :
              state == SETUP ? (valid ? FILL : DONE) :
              state == FILL  ? (fire && last ? DONE : FILL) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      color <= '0;
      bad <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        x0 <= cmd_x0;
        x1 <= cmd_x1;
        y0 <= cmd_y0;
        y1 <= cmd_y1;
        color <= cmd_color;
      end
      if (state == SETUP) bad <= !valid;
      if (state == SETUP && valid) begin
        x1 <= cx1;
        y1 <= cy1;
        x <= x0;
        y <= y0;
        base <= row_base(y0);
        addr <= row_base(y0) + AW'(x0);
      end
      if (fire && !last) begin
        if (row_end) begin
          x <= x0;
          y <= y + 1'b1;
          base <= base + AW'(H_RES);
          addr <= base + AW'(H_RES) + AW'(x0);
        end else begin
          x <= x + 1'b1;
          addr <= addr + 1'b1;
        end
      end
    end
  end
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign wr_en = state == FILL;
  assign done = state == DONE;
  assign err = done && bad;
  assign wr_addr = addr;
  assign wr_data = color;
endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 H_RES, default 640, visible pixels per line.
REQ-002 V_RES, default 480, visible lines per frame.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_x0, cmd_x1  in  10 each  inclusive column bounds.
REQ-008 cmd_y0, cmd_y1  in  9 each  inclusive row bounds.
REQ-009 cmd_color  in  8  RGB332 pixel: r[7:5], g[4:2], b[1:0].
REQ-010 wr_en  out  1  VRAM write request.
REQ-011 wr_addr  out  19  linear pixel address, y*H_RES+x.
REQ-012 wr_data  out  8  RGB332 pixel to write.
REQ-013 wr_ready  in  1  VRAM accepts the write this cycle.
REQ-014 busy  out  1  command in progress.
REQ-015 done  out  1  one-cycle pulse at command completion.
REQ-016 err  out  1  one-cycle pulse, coincident with done, for a rejected command.

Function
REQ-017 FSM states: IDLE, SETUP, FILL, DONE.
REQ-018 cmd_ready = 1 only in IDLE; accept on cmd_valid && cmd_ready; latch all cmd fields.
REQ-019 IDLE->SETUP on accept; SETUP->FILL if rectangle valid, else SETUP->DONE with err.
REQ-020 SETUP clamps x1 to min(x1,H_RES-1) and y1 to min(y1,V_RES-1).
REQ-021 Invalid: x0>=H_RES, y0>=V_RES, x0>x1 or y0>y1 after clamp; zero writes issued.
REQ-022 SETUP computes row base y0*H_RES by shift-add (y*512+y*128 for 640); no generic multiplier.
REQ-023 FILL issues writes in raster order: x0..x1 within a row, rows y0..y1.
REQ-024 Write handshake: a write completes when wr_en && wr_ready; wr_addr and wr_data held stable while wr_en=1 and wr_ready=0.
REQ-025 Row advance adds H_RES to row base; address never wraps past H_RES*V_RES-1.
REQ-026 Throughput one pixel per cycle while wr_ready=1.
REQ-027 Latency: accept at cycle N -> first wr_en at N+2.
REQ-028 FILL->DONE on completed write of (x1,y1); DONE asserts done for one cycle, then IDLE.
REQ-029 busy = 1 in SETUP, FILL, DONE; 0 in IDLE.
REQ-030 cmd_valid ignored while busy; no queuing.
REQ-031 wr_data = latched cmd_color for every write of a command.

Reset
REQ-032 rst forces IDLE; cmd_ready=1 from the first cycle after rst deasserts, busy=0, wr_en=0, done=0, err=0, wr_addr=0, wr_data=0.
REQ-033 rst during FILL aborts the command: wr_en=0 in the cycle after rst is sampled; no done pulse.

Structure
REQ-034 Shared package holds H_RES, V_RES, address width 19, RGB332 field positions and the FSM state encoding.
REQ-035 One sub-module, rect_clip, SHALL perform clamp and validity check combinationally for SETUP.

Verification
REQ-036 Single pixel (5,7)-(5,7), color 0xE0, wr_ready=1 -> one write, addr 4485, data 0xE0; done at N+3.
REQ-037 Full screen (0,0)-(639,479), color 0xFF -> 307200 writes, first addr 0, last addr 307199, then one done pulse.
REQ-038 Clip (630,470)-(700,500) -> x 630..639, y 470..479; 100 writes; last addr 307199; err=0.
REQ-039 Inverted (10,0)-(5,0) and x0=640 -> zero writes; done and err pulse together.
REQ-040 4x2 rect with wr_ready toggling 1,0,0,1 -> 8 unique addresses in raster order; addr/data stable across stalls.
REQ-041 rst asserted after 100 writes of a full-screen fill -> wr_en low next cycle, no done; a new 1x1 command is then accepted and completes normally.
